pe_cluster_sequencer: RTL
=========================

# pe_cluster_sequencer

Cluster-level sequencer that drives the per-PE controllers in a PE cluster. For each processing pass it broadcasts the load-start pulse, meters input load beats from the router, and signals load completion. It then collects calculation-finish from every PE and meters partial-sum enqueue beats toward the output router. It sits directly upstream of the PE controllers, whose per-PE state goes IDLE→LOAD→CAL→IDLE, and repeats passes until the configured pass count is reached.

## Interface
- NUM_PE, 4: number of PEs sequenced.
- LOAD_CNT_W, 8: width of load-beat counter and cfg_load_len.
- PSUM_CNT_W, 6: width of psum-beat counter and cfg_psum_len.
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin job; sampled only in IDLE.
- cfg_load_len  in  LOAD_CNT_W  load beats per pass.
- cfg_psum_len  in  PSUM_CNT_W  psum beats per pass.
- cfg_num_pass  in  8  passes per job; 0 treated as 1.
- in_valid  in  1  router load beat valid.
- in_ready  out  1  sequencer accepts load beat.
- pe_do_load_en  out  1  broadcast load-start pulse to all PEs.
- pe_write_fin  out  1  broadcast load-complete pulse.
- pe_cal_fin  in  NUM_PE  per-PE calculation finished.
- pe_psum_enq_en  out  1  broadcast psum enqueue strobe.
- psum_out_ready  in  1  downstream accepts psum beat.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky CAL-timeout flag (see Configuration).

## Operation
- States: IDLE, ISSUE, LOAD, WFIN, CAL, DRAIN, DONE. All outputs are Moore-decoded from state, except pe_psum_enq_en.
- IDLE: start=1 latches cfg_* into internal registers, clears the pass counter and goes to ISSUE. start in any other state is ignored.
- ISSUE: pe_do_load_en=1 for one cycle. Clears load counter, psum counter and cal flags. Goes to LOAD, or to WFIN if latched load_len=0.
- LOAD: in_ready=1. A beat is accepted when in_valid=1. The state advances to WFIN in the cycle after the beat that brings the accepted count to load_len.
- WFIN: pe_write_fin=1 for one cycle, then CAL.
- CAL: cal_flags |= pe_cal_fin every cycle. Goes to DRAIN when (cal_flags | pe_cal_fin) is all ones; a same-cycle finish counts. Goes to DONE/ISSUE instead of DRAIN when psum_len=0, following the DRAIN exit rule.
- DRAIN: pe_psum_enq_en = psum_out_ready. Each strobe counts one beat. After psum_len beats, the pass counter increments. If it then equals max(num_pass,1), go to DONE; otherwise go to ISSUE.
- DONE: done=1 for one cycle, then IDLE.
- Counters do not wrap within a pass: load_len and psum_len are bounded by their widths, and comparison is exact equality.

## Timing
- Reset values: state=IDLE, in_ready=0, pe_do_load_en=0, pe_write_fin=0, pe_psum_enq_en=0, busy=0, done=0, err=0. Counters, cal flags and latched config are cleared.
- Reset mid-job returns to IDLE on the next edge with no further PE strobes. PEs are reset by the same signal.
- No-stall latency with start at cycle 0:
  - ISSUE at cycle 1, LOAD at cycles 2..L+1, WFIN at cycle L+2, CAL at cycle L+3.
  - DRAIN at cycles L+4..L+3+P, DONE at cycle L+4+P.
- Multi-pass: the next ISSUE immediately follows the last DRAIN beat, with no idle cycle.
- Backpressure: in_valid=0 stalls LOAD, and psum_out_ready=0 stalls DRAIN, indefinitely.

## Configuration
- SEQ_CAL_TIMEOUT_EN defined: a 16-bit counter runs in CAL and clears on CAL entry. When it reaches 65535 without all flags set, err is set (sticky until reset) and the state goes to DONE. done still pulses.
- SEQ_CAL_TIMEOUT_EN undefined: no counter, CAL waits forever, and err is tied to 0.

## Test plan
- Single pass, L=4, P=2, all pe_cal_fin asserted at the first CAL cycle, no stalls: start at cycle 0 -> pe_do_load_en at cycle 1, pe_write_fin at cycle 6, psum strobes at cycles 8–9, done at cycle 10.
- Staggered cal_fin: PE0 at CAL+0, PE3 at CAL+5, the others at CAL+2, each a one-cycle pulse -> DRAIN entered at CAL+6.
- Backpressure, L=3: in_valid toggles every cycle and psum_out_ready is low for 3 cycles in DRAIN -> exactly 3 loads accepted, exactly P strobes, and no strobe while ready=0.
- cfg_num_pass=3, with start pulsed again mid-job -> 3 ISSUE pulses, one done pulse, and the extra start is ignored. cfg_num_pass=0 -> exactly 1 pass.
- Zero lengths, L=0 and P=0 -> ISSUE, WFIN, CAL, DONE with no in_ready and no pe_psum_enq_en.
- Reset asserted in LOAD -> all outputs 0 on the next cycle. With SEQ_CAL_TIMEOUT_EN and cal_fin never asserted, err=1 and done pulses 65536 cycles after CAL entry.

Source files
------------

// File: rtl/pe_cluster_sequencer_if.sv
// rtl/pe_cluster_sequencer_if.sv - router load stream and PE broadcast/collect signals of the cluster sequencer
interface pe_cluster_sequencer_if #(
  parameter int NUM_PE = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              pe_do_load_en;
  logic              pe_write_fin;
  logic [NUM_PE-1:0] pe_cal_fin;
  logic              pe_psum_enq_en;
  logic              psum_out_ready;

  modport master (
    input  in_valid,
    input  pe_cal_fin,
    input  psum_out_ready,
    output in_ready,
    output pe_do_load_en,
    output pe_write_fin,
    output pe_psum_enq_en
  );

  modport slave (
    output in_valid,
    output pe_cal_fin,
    output psum_out_ready,
    input  in_ready,
    input  pe_do_load_en,
    input  pe_write_fin,
    input  pe_psum_enq_en
  );
endinterface

// File: rtl/pe_cluster_sequencer.sv
// rtl/pe_cluster_sequencer.sv - PE cluster pass sequencer: issue, load metering, calc collect, psum drain
// Optional feature macro: SEQ_CAL_TIMEOUT_EN enables a 16-bit CAL watchdog driving the sticky err flag.
module pe_cluster_sequencer #(
  parameter int NUM_PE     = 4,
  parameter int LOAD_CNT_W = 8,
  parameter int PSUM_CNT_W = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LOAD_CNT_W-1:0] cfg_load_len,
  input  logic [PSUM_CNT_W-1:0] cfg_psum_len,
  input  logic [7:0]            cfg_num_pass,
  pe_cluster_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_LOAD,
    S_WFIN,
    S_CAL,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [LOAD_CNT_W-1:0] load_len_q;
  logic [LOAD_CNT_W-1:0] load_cnt;
  logic [LOAD_CNT_W-1:0] load_cnt_inc;
  logic [PSUM_CNT_W-1:0] psum_len_q;
  logic [PSUM_CNT_W-1:0] psum_cnt;
  logic [PSUM_CNT_W-1:0] psum_cnt_inc;
  logic [7:0]            num_pass_q;
  logic [7:0]            pass_cnt;
  logic [7:0]            pass_cnt_inc;
  logic [NUM_PE-1:0]     cal_flags;
  logic [NUM_PE-1:0]     cal_flags_next;
  logic                  all_fin;
  logic                  pass_step;

`ifdef SEQ_CAL_TIMEOUT_EN
  logic [15:0]           cal_timer;
  logic                  cal_timeout;
  logic                  err_q;
`endif

  assign load_cnt_inc   = load_cnt + LOAD_CNT_W'(1);
  assign psum_cnt_inc   = psum_cnt + PSUM_CNT_W'(1);
  assign pass_cnt_inc   = pass_cnt + 8'd1;
  // A PE finishing in the same cycle the last flag would be checked still counts.
  assign cal_flags_next = cal_flags | bus.pe_cal_fin;
  assign all_fin        = &cal_flags_next;

`ifdef SEQ_CAL_TIMEOUT_EN
  assign cal_timeout    = (cal_timer == 16'hFFFF) && !all_fin;
`endif

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode and strobes; everything is Moore except psum enqueue, which follows downstream ready
  always_comb begin
    state_next         = state;
    bus.in_ready       = 1'b0;
    bus.pe_do_load_en  = 1'b0;
    bus.pe_write_fin   = 1'b0;
    bus.pe_psum_enq_en = 1'b0;
    pass_step          = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        bus.pe_do_load_en = 1'b1;
        state_next = (load_len_q == '0) ? S_WFIN : S_LOAD;
      end
      S_LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && (load_cnt_inc == load_len_q)) state_next = S_WFIN;
      end
      S_WFIN: begin
        bus.pe_write_fin = 1'b1;
        state_next = S_CAL;
      end
      S_CAL: begin
        if (all_fin) begin
          if (psum_len_q == '0) begin
            // No psum beats: the pass closes here exactly as it would at the end of DRAIN.
            pass_step  = 1'b1;
            state_next = (pass_cnt_inc == num_pass_q) ? S_DONE : S_ISSUE;
          end else begin
            state_next = S_DRAIN;
          end
        end
`ifdef SEQ_CAL_TIMEOUT_EN
        else if (cal_timeout) begin
          state_next = S_DONE;
        end
`endif
      end
      S_DRAIN: begin
        bus.pe_psum_enq_en = bus.psum_out_ready;
        if (bus.psum_out_ready && (psum_cnt_inc == psum_len_q)) begin
          pass_step  = 1'b1;
          state_next = (pass_cnt_inc == num_pass_q) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Latched job configuration, per-pass beat counters, pass counter and PE finish flags
  always_ff @(posedge clock) begin
    if (reset) begin
      load_len_q <= '0;
      psum_len_q <= '0;
      num_pass_q <= '0;
      load_cnt   <= '0;
      psum_cnt   <= '0;
      pass_cnt   <= '0;
      cal_flags  <= '0;
    end else begin
      if (pass_step) pass_cnt <= pass_cnt_inc;
      case (state)
        S_IDLE: begin
          if (start) begin
            load_len_q <= cfg_load_len;
            psum_len_q <= cfg_psum_len;
            // A pass count of zero still runs one pass.
            num_pass_q <= (cfg_num_pass == 8'd0) ? 8'd1 : cfg_num_pass;
            pass_cnt   <= '0;
          end
        end
        S_ISSUE: begin
          load_cnt  <= '0;
          psum_cnt  <= '0;
          cal_flags <= '0;
        end
        S_LOAD: begin
          if (bus.in_valid) load_cnt <= load_cnt_inc;
        end
        S_CAL: begin
          cal_flags <= cal_flags_next;
        end
        S_DRAIN: begin
          if (bus.psum_out_ready) psum_cnt <= psum_cnt_inc;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SEQ_CAL_TIMEOUT_EN
  // CAL watchdog: restarts on CAL entry, raises a sticky err when it expires with PEs still outstanding
  always_ff @(posedge clock) begin
    if (reset) begin
      cal_timer <= '0;
      err_q     <= 1'b0;
    end else if (state == S_WFIN) begin
      cal_timer <= '0;
    end else if (state == S_CAL) begin
      cal_timer <= cal_timer + 16'd1;
      if (cal_timeout) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
